// File: rtl/bin2bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
// Holds the state encoding, the BCD digit width and the digit-count check used at elaboration.
package bin2bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Number of decimal digits needed to hold the largest width-bit unsigned value.
  function automatic int min_digits(input int width);
    int v;
    int d;
    v = (1 << width) - 1;
    d = 1;
    while (v >= 10) begin
      v = v / 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before it is doubled.
// Inputs 10..15 cannot occur in a valid conversion, so their mapping is irrelevant.
module bcd_add3_cell
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one operand bit per clock through a shared bank of add-3 cells.
// Produces packed BCD digits plus a leading-zero blank mask for the display drivers.
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]       blank
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);

  if ((WIDTH < 4) || (WIDTH > 16)) begin : g_width_chk
    $fatal(1, "bin2bcd_seq_ctrl: WIDTH must lie in 4..16");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $fatal(1, "bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
  end

  state_t             state;
  logic [WIDTH-1:0]   bin_reg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scr_corr;
  logic [SCR_W-1:0]   scr_next;
  logic [CNT_W-1:0]   cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (scr_corr[g*BCD_W +: BCD_W])
    );
  end

  // Corrected scratch and operand shift left as one register; operand MSB feeds scratch bit 0.
  assign scr_next = {scr_corr[SCR_W-2:0], bin_reg[WIDTH-1]};

  function automatic logic [DIGITS-1:0] blank_mask(input logic [SCR_W-1:0] s);
    logic [DIGITS-1:0] m;
    logic              hi_zero;
    m       = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero & (s[i*BCD_W +: BCD_W] == 4'd0);
      m[i]    = hi_zero;
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      blank   <= BLANK_RST;
      bin_reg <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_reg <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= scr_next;
          bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
          if (cnt == CNT_LAST) begin
            bcd_out <= scr_next;
            blank   <= blank_mask(scr_next);
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Self-checking bench for bin2bcd_seq_ctrl: cycle-level reference model plus directed literal checks.
module tb_bin2bcd_seq_ctrl;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int W2 = 10;
  localparam int D2 = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    bin_in = '0;
  logic            ready, busy, done;
  logic [4*D-1:0]  bcd_out;
  logic [D-1:0]    blank;

  logic            start2 = 1'b0;
  logic [W2-1:0]   bin_in2 = '0;
  logic            ready2, busy2, done2;
  logic [4*D2-1:0] bcd_out2;
  logic [D2-1:0]   blank2;

  always #5 clk = ~clk;

  bin2bcd_seq_ctrl #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ready(ready), .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank)
  );

  bin2bcd_seq_ctrl #(.WIDTH(W2), .DIGITS(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin_in2),
    .ready(ready2), .busy(busy2), .done(done2), .bcd_out(bcd_out2), .blank(blank2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, packed 4 bits per digit, by plain division.
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Bit i set when digit i lies above the most significant nonzero digit.
  function automatic logic [31:0] ref_blank(input int v, input int nd);
    logic [31:0] r;
    int t;
    int n;
    r = '0;
    t = v;
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    for (int i = 0; i < nd; i++) r[i] = (i >= n);
    return r;
  endfunction

  // Reference model: an accepted request keeps the block busy W+1 cycles; the last one is done.
  int          m_rem;
  int          m_val;
  logic [31:0] m_bcd;
  logic [31:0] m_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem   <= 0;
      m_val   <= 0;
      m_bcd   <= '0;
      m_blank <= ref_blank(0, D);
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem <= W + 1;
        m_val <= int'(bin_in);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_bcd   <= ref_bcd(m_val, D);
        m_blank <= ref_blank(m_val, D);
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(m_rem == 0));
    check("busy", 32'(busy), 32'(m_rem != 0));
    check("done", 32'(done), 32'(m_rem == 1));
    check("bcd_out", 32'(bcd_out), m_bcd);
    check("blank", 32'(blank), m_blank);
    if (done) done_cnt++;
  end

  task automatic run(input int v, input logic [31:0] exp_bcd, input logic [31:0] exp_blank);
    int n;
    bit got;
    @(negedge clk); #1;
    start  = 1'b1;
    bin_in = W'(v);
    n   = 0;
    got = 0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      #1 start = 1'b0;
    end
    check("latency", 32'(n), 32'(W + 1));
    check("lit_bcd", 32'(bcd_out), exp_bcd);
    check("lit_blank", 32'(blank), exp_blank);
    @(negedge clk);
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  task automatic run2(input int v, input logic [31:0] exp_bcd, input logic [31:0] exp_blank);
    int n;
    bit got;
    @(negedge clk); #1;
    start2  = 1'b1;
    bin_in2 = W2'(v);
    n   = 0;
    got = 0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (done2) got = 1;
      #1 start2 = 1'b0;
    end
    check("w10_latency", 32'(n), 32'(W2 + 1));
    check("w10_bcd", 32'(bcd_out2), exp_bcd);
    check("w10_blank", 32'(blank2), exp_blank);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bcd_at_done;
    int first_dones;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h000);
    check("rst_blank", 32'(blank), 32'b110);
    #1 rst_n = 1'b1;

    run(255, 32'h255, 32'b000);
    run(0,   32'h000, 32'b110);
    run(7,   32'h007, 32'b110);
    run(99,  32'h099, 32'b100);
    run(100, 32'h100, 32'b000);

    // Second request during a conversion is dropped.
    done_cnt = 0;
    @(negedge clk); #1;
    start = 1'b1; bin_in = 8'd200;
    @(negedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 start = 1'b1; bin_in = 8'd5;
    @(negedge clk); #1 start = 1'b0;
    bcd_at_done = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) bcd_at_done = 32'(bcd_out);
    end
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_bcd", bcd_at_done, 32'h200);

    // Back-to-back conversions over every operand.
    done_cnt = 0;
    @(negedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bin_in = W'(i);
      repeat (W + 2) @(negedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_done_count", 32'(done_cnt), 32'd256);
    check("b2b_last_bcd", 32'(bcd_out), 32'h255);

    // Asynchronous reset mid-conversion.
    done_cnt = 0;
    @(negedge clk); #1;
    start = 1'b1; bin_in = 8'd150;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_bcd", 32'(bcd_out), 32'h000);
    check("arst_blank", 32'(blank), 32'b110);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run(42, 32'h042, 32'b100);

    first_dones = done_cnt;
    check("arst_then_one_done", 32'(first_dones), 32'd1);

    run2(1023, 32'h1023, 32'b0000);
    run2(5,    32'h0005, 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Sequential binary-to-BCD conversion controller. It converts a WIDTH-bit unsigned binary operand into DIGITS packed BCD digits by time-sharing one bank of per-digit add-3 correction cells, using the shift-add-3 (double-dabble) method, one bit per clock. It replaces a cascade of combinational 6-bit converter stages when operand width grows. Its output feeds the 7-segment display drivers, including a leading-zero blank mask.

Parameters:
WIDTH, 8, binary operand width in bits; legal range 4..16.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1, checked at elaboration (fatal if violated).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  conversion request; sampled only when ready=1.
bin_in  input  WIDTH  binary operand; captured on the accepted start edge only.
ready  output  1  high in IDLE only; start is accepted when start=1 and ready=1.
busy  output  1  high in SHIFT and DONE.
done  output  1  single-cycle pulse; bcd_out and blank are valid from this cycle onward.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0]; held until the next done.
blank  output  DIGITS  leading-zero mask; bit i=1 when digit i and all higher digits are 0; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, bcd_out=0, blank = all ones except bit 0, internal shift/scratch/counter registers=0. Reset mid-conversion abandons the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
  - IDLE: on start=1, load bin_reg<=bin_in, clear the scratch BCD register and cnt<=0, then go to SHIFT. With start=0, stay in IDLE.
  - SHIFT, each cycle:
    - Every scratch digit >=5 gets +3 (combinational add-3 cells, all digits in parallel).
    - The corrected scratch:bin_reg pair shifts left by 1; bin_reg MSB enters scratch bit 0.
    - cnt++.
    - On the cycle where cnt==WIDTH-1: go to DONE, and load bcd_out and blank from the final shifted scratch value on the same edge.
  - DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- Latency: start accepted at edge k; SHIFT occupies the WIDTH cycles after k; done is high in the cycle following edge k+WIDTH. Minimum issue interval is WIDTH+2 cycles, because DONE does not accept start.
- start while busy is ignored, not queued. bin_in changes after acceptance have no effect.
- With start held high continuously, conversions run back-to-back with period WIDTH+2, each capturing bin_in at its IDLE edge.
- Arithmetic: scratch is 4*DIGITS bits; the add-3 result per digit is 4 bits with no carry between digits. Unused upper digits stay 0. The result is exact for all inputs 0..2^WIDTH-1.
- Corrected digit values never exceed 9 at DONE. Digit values 10..15 are unreachable; the add-3 cell maps them as don't-care.
- cnt width is clog2(WIDTH), and cnt never wraps inside a conversion.

Decomposition:
- Package bin2bcd_pkg:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - constant function min_digits(width) used by the elaboration check;
  - BCD_W=4.
- One sub-module, bcd_add3_cell: a 4-bit combinational cell computing d>=5 ? d+3 : d, instantiated DIGITS times by generate.
- FSM, counter and shift registers stay in bin2bcd_seq_ctrl.

Test Plan:
- WIDTH=8, DIGITS=3; start=1 with bin_in=8'd255 for one cycle -> done pulse 9 cycles after the accepting edge (cycle k+9), bcd_out=12'h255, blank=3'b000, ready returns to 1 the cycle after done.
- bin_in=0 -> bcd_out=12'h000, blank=3'b110. bin_in=7 -> 12'h007, blank=3'b110. bin_in=99 -> 12'h099, blank=3'b100. bin_in=100 -> 12'h100, blank=3'b000.
- Start accepted with bin_in=200, then start pulsed again with bin_in=5 at cycle k+3 -> second request ignored; single done with bcd_out=12'h200; busy=1 through k+9.
- start held high with bin_in stepping 0..255 -> a done pulse every 10 cycles; each bcd_out matches a reference model of the value sampled at its accepting edge; exhaustive compare of all 256 values.
- rst_n pulsed low at cycle k+4 of a conversion of 150 -> asynchronous return to IDLE, no done, bcd_out=0, blank=3'b110; next start with 42 -> 12'h042, blank=3'b100.
- Parameter sweep WIDTH=10/DIGITS=4: bin_in=1023 -> 16'h1023 at cycle k+11; elaboration with WIDTH=10, DIGITS=3 must fail the check.
